row_select_sequencer: RTL
=========================

Name: row_select_sequencer

Overview:
- Parametrised successor to the compute tile's fixed 4-to-16 one-hot decoder.
- Accepts a burst command (base index, length) and walks a one-hot row select across 2^SEL_W outputs, one row per accepted beat, with wrap-around.
- Downstream back-pressure via valid/ready.
- Sits between the tile controller and the weight/activation row arrays; drives their row write/read enables.

Parameters:
- SEL_W, 4, index width; output count OUT_N = 2^SEL_W (derived localparam, not overridable).
- LEN_W, SEL_W+1, burst length width; allows a full sweep of OUT_N rows.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_base  in  SEL_W  first row index.
- cmd_len  in  LEN_W  number of rows to select.
- sel_valid  out  1  sel_onehot is a live beat.
- sel_ready  in  1  downstream consumes the beat.
- sel_onehot  out  OUT_N  one-hot row select; all zero when sel_valid=0.
- sel_idx  out  SEL_W  binary index of the current row.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state=IDLE, cmd_ready=1, sel_valid=0, sel_onehot=0, sel_idx=0, busy=0, done=0, remaining=0.
- States:
  - IDLE: cmd_ready=1, sel_valid=0.
  - RUN: cmd_ready=0, sel_valid=1.
- IDLE, command accepted with cmd_len!=0: next cycle RUN, cur_idx=cmd_base, remaining=cmd_len. The first beat is visible 1 cycle after the accept.
- IDLE, command accepted with cmd_len==0: stay IDLE, no beat, done=1 the next cycle.
- RUN, sel_ready=1: beat consumed.
  - remaining>1: cur_idx = (cur_idx+1) mod OUT_N (natural SEL_W wrap, e.g. 15 -> 0), remaining-1.
  - remaining==1: go to IDLE, done=1 the next cycle, sel_valid=0 the next cycle.
- RUN, sel_ready=0: cur_idx, sel_onehot and sel_idx hold stable; no beat lost or repeated.
- Outputs:
  - sel_onehot = sel_valid ? (1 << cur_idx) : 0, built from registered state only. No combinational path from any input to any output.
  - busy = (state==RUN).
- Back-to-back bursts: cmd_ready is asserted in the cycle after the last beat. Minimum one idle cycle between bursts.
- cmd_len > OUT_N is legal: the walk wraps and revisits rows.
- Reset asserted mid-burst: immediate return to reset values; burst abandoned; no done pulse.
- cmd_valid while busy: ignored and not accepted. The issuer must hold cmd_valid.

Optional Feature:
- Macro: ROW_SEL_BCAST_EN.
- Defined:
  - Adds input port cmd_bcast (1 bit).
  - An accepted command with cmd_bcast=1 produces exactly one beat with sel_onehot all ones and sel_idx=cmd_base. cmd_len is ignored.
  - done pulses the cycle after that beat is consumed.
- Undefined: port absent; every command walks normally.

Decomposition:
- compute_tile_pkg: state enum (IDLE, RUN) and default SEL_W constant.
- Sub-module onehot_decoder: parametrised SEL_W -> 2^SEL_W combinational decoder with an enable input. Instantiated once; reusable elsewhere in the tile.

Test Plan:
- Reset then base=3, len=4, sel_ready=1 → beats with sel_onehot 0x0008, 0x0010, 0x0020, 0x0040 on consecutive cycles; done the cycle after the 4th beat; cmd_ready high again.
- base=14, len=4 → wrap sequence 0x4000, 0x8000, 0x0001, 0x0002.
- base=5, len=3, sel_ready toggled 1,0,0,1,1 → each beat held stable while stalled; exactly 3 distinct beats; sel_idx 5, 6, 7.
- len=0 → no sel_valid; single done pulse one cycle after accept.
- rst raised at the 2nd beat of a len=8 burst → all outputs return to reset values asynchronously; no done; a new command is accepted after release.
- ROW_SEL_BCAST_EN defined, cmd_bcast=1, len=9 → one beat with sel_onehot=0xFFFF, then done.

Source files
------------

// File: rtl/compute_tile_pkg.sv
// Shared compute-tile types: row-sequencer state encoding and default index width.
package compute_tile_pkg;

    localparam int SEL_W_DEFAULT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/row_select_sequencer_onehot_decoder.sv
// Parametrised SEL_W -> 2^SEL_W one-hot decoder with enable; output is all zero when disabled.
module onehot_decoder #(
    parameter int SEL_W = 4
) (
    input  logic                    i_en,
    input  logic [SEL_W-1:0]        i_idx,
    output logic [(1<<SEL_W)-1:0]   o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/row_select_sequencer.sv
// Burst row-select sequencer: walks a one-hot select from cmd_base for cmd_len beats with wrap.
// Optional broadcast command (single all-ones beat) enabled by defining ROW_SEL_BCAST_EN.
module row_select_sequencer
    import compute_tile_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEFAULT,
    parameter int LEN_W = SEL_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [SEL_W-1:0]        cmd_base,
    input  logic [LEN_W-1:0]        cmd_len,
`ifdef ROW_SEL_BCAST_EN
    input  logic                    cmd_bcast,
`endif
    output logic                    sel_valid,
    input  logic                    sel_ready,
    output logic [(1<<SEL_W)-1:0]   sel_onehot,
    output logic [SEL_W-1:0]        sel_idx,
    output logic                    busy,
    output logic                    done
);

    localparam int OUT_N = 1 << SEL_W;

    seq_state_e         r_state;
    seq_state_e         w_next_state;
    logic [SEL_W-1:0]   r_cur_idx;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_done;

    logic               w_accept;
    logic               w_cmd_bcast;
    logic               w_cmd_walk;
    logic               w_beat_take;
    logic               w_last_beat;
    logic               w_bcast_active;
    logic [OUT_N-1:0]   w_dec_onehot;

    assign w_accept    = cmd_valid && cmd_ready;
    assign w_beat_take = (r_state == RUN) && sel_ready;
    assign w_last_beat = w_beat_take && (r_remaining == LEN_W'(1));

`ifdef ROW_SEL_BCAST_EN
    logic r_bcast;

    assign w_cmd_bcast    = cmd_bcast;
    assign w_bcast_active = r_bcast && (r_state == RUN);

    // Broadcast flag lives for exactly the single beat of a broadcast burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcast <= 1'b0;
        end else if (w_accept) begin
            r_bcast <= cmd_bcast;
        end else if (w_last_beat) begin
            r_bcast <= 1'b0;
        end
    end
`else
    assign w_cmd_bcast    = 1'b0;
    assign w_bcast_active = 1'b0;
`endif

    // A zero-length walk is accepted but never leaves IDLE; broadcast ignores length.
    assign w_cmd_walk = w_accept && (w_cmd_bcast || (cmd_len != '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_cmd_walk) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_last_beat) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Index and beat counter only move on a consumed beat, so a stall holds the row stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_idx   <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (w_accept && !w_cmd_walk) || w_last_beat;
            if (w_cmd_walk) begin
                r_cur_idx   <= cmd_base;
                r_remaining <= w_cmd_bcast ? LEN_W'(1) : cmd_len;
            end else if (w_beat_take) begin
                r_remaining <= r_remaining - LEN_W'(1);
                if (!w_last_beat) begin
                    r_cur_idx <= r_cur_idx + SEL_W'(1);
                end
            end
        end
    end

    always_comb begin
        cmd_ready = (r_state == IDLE);
        sel_valid = (r_state == RUN);
        busy      = (r_state == RUN);
        done      = r_done;
        sel_idx   = r_cur_idx;
    end

    onehot_decoder #(
        .SEL_W    (SEL_W)
    ) u_decoder (
        .i_en     (sel_valid),
        .i_idx    (r_cur_idx),
        .o_onehot (w_dec_onehot)
    );

    assign sel_onehot = w_dec_onehot | {OUT_N{w_bcast_active}};

endmodule
